// File: rtl/multi_dly_timer.sv
// multi_dly_timer: NUM_CH independent delay channels, each with a prescaled
// tick, a CNT_W-bit delay counter and one-shot / periodic expiry modes.
// Expiry happens (N+1)*PRESCALE edges after the start or retrigger edge.
module multi_dly_timer #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1
) (
    input  logic                    clk_in,
    input  logic                    iRst,
    input  logic [NUM_CH-1:0]       dly_timer_en,
    input  logic [NUM_CH*CNT_W-1:0] dly_time,
    input  logic [NUM_CH-1:0]       dly_mode,
    input  logic [NUM_CH-1:0]       dly_retrig,
    output logic [NUM_CH-1:0]       dly_timeout,
    output logic [NUM_CH-1:0]       dly_pulse,
    output logic                    dly_busy
);

    localparam int unsigned       PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]     PRE_MAX = PW'(PRESCALE - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic              hist_vld;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] count_nxt;

    // Enable history only becomes valid one edge after reset, so an enable
    // already high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk_in or posedge iRst) begin
        if (iRst) hist_vld <= 1'b0;
        else      hist_vld <= 1'b1;
    end

    // Registered copy of the enables for rising-edge detection.
    always_ff @(posedge clk_in or posedge iRst) begin
        if (iRst) en_q <= '0;
        else      en_q <= dly_timer_en;
    end

    // Busy follows the next-state of every channel so it changes on the
    // same edge that enters or leaves COUNT.
    always_ff @(posedge clk_in or posedge iRst) begin
        if (iRst) dly_busy <= 1'b0;
        else      dly_busy <= |count_nxt;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [1:0]       state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic [CNT_W-1:0] n_lat, n_lat_nxt;
        logic             mode_lat, mode_nxt;
        logic [PW-1:0]    pre, pre_nxt;
        logic             tmo_q, tmo_nxt;
        logic             pls_q, pls_nxt;
        logic             rise, tick;

        assign rise = dly_timer_en[c] & ~en_q[c] & hist_vld;
        assign tick = (pre == PRE_MAX);

        // Channel next-state: enable low wins over everything, then
        // retrigger wins over an expiry tick.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            n_lat_nxt = n_lat;
            mode_nxt  = mode_lat;
            pre_nxt   = pre;
            tmo_nxt   = tmo_q;
            pls_nxt   = 1'b0;
            if (!dly_timer_en[c]) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                pre_nxt   = '0;
                tmo_nxt   = 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            n_lat_nxt = dly_time[c*CNT_W +: CNT_W];
                            mode_nxt  = dly_mode[c];
                            cnt_nxt   = '0;
                            pre_nxt   = '0;
                            state_nxt = ST_COUNT;
                        end
                    end
                    ST_COUNT: begin
                        if (dly_retrig[c]) begin
                            cnt_nxt = '0;
                            pre_nxt = '0;
                            tmo_nxt = 1'b0;
                        end else if (tick) begin
                            pre_nxt = '0;
                            if (cnt < n_lat) begin
                                cnt_nxt = cnt + 1'b1;
                            end else begin
                                pls_nxt = 1'b1;
                                cnt_nxt = '0;
                                if (!mode_lat) begin
                                    state_nxt = ST_DONE;
                                    tmo_nxt   = 1'b1;
                                end
                            end
                        end else begin
                            pre_nxt = pre + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (dly_retrig[c]) begin
                            cnt_nxt   = '0;
                            pre_nxt   = '0;
                            tmo_nxt   = 1'b0;
                            state_nxt = ST_COUNT;
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        pre_nxt   = '0;
                        tmo_nxt   = 1'b0;
                    end
                endcase
            end
        end

        // Channel state registers.
        always_ff @(posedge clk_in or posedge iRst) begin
            if (iRst) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                n_lat    <= '0;
                mode_lat <= 1'b0;
                pre      <= '0;
                tmo_q    <= 1'b0;
                pls_q    <= 1'b0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                n_lat    <= n_lat_nxt;
                mode_lat <= mode_nxt;
                pre      <= pre_nxt;
                tmo_q    <= tmo_nxt;
                pls_q    <= pls_nxt;
            end
        end

        assign count_nxt[c]   = (state_nxt == ST_COUNT);
        assign dly_timeout[c] = tmo_q;
        assign dly_pulse[c]   = pls_q;
    end

endmodule

// File: tb/tb_multi_dly_timer.sv
// tb_multi_dly_timer: scoreboard bench for multi_dly_timer. Expected expiry
// edges are pushed when a channel is started/retriggered and popped when the
// matching dly_pulse is observed.
module tb_multi_dly_timer;

    logic clk_in = 1'b0;
    logic iRst   = 1'b1;

    // unit 0: defaults; unit 1: PRESCALE=4; unit 2: one channel, CNT_W=4
    logic [3:0]  en0 = '0, mode0 = '0, rtg0 = '0, tmo0, pls0;
    logic [63:0] time0 = '0;
    logic        busy0;
    logic [3:0]  en1 = '0, mode1 = '0, rtg1 = '0, tmo1, pls1;
    logic [63:0] time1 = '0;
    logic        busy1;
    logic [0:0]  en2 = '0, mode2 = '0, rtg2 = '0, tmo2, pls2;
    logic [3:0]  time2 = '0;
    logic        busy2;

    multi_dly_timer #(.NUM_CH(4), .CNT_W(16), .PRESCALE(1)) u_dut0 (
        .clk_in(clk_in), .iRst(iRst), .dly_timer_en(en0), .dly_time(time0),
        .dly_mode(mode0), .dly_retrig(rtg0), .dly_timeout(tmo0),
        .dly_pulse(pls0), .dly_busy(busy0));

    multi_dly_timer #(.NUM_CH(4), .CNT_W(16), .PRESCALE(4)) u_dut1 (
        .clk_in(clk_in), .iRst(iRst), .dly_timer_en(en1), .dly_time(time1),
        .dly_mode(mode1), .dly_retrig(rtg1), .dly_timeout(tmo1),
        .dly_pulse(pls1), .dly_busy(busy1));

    multi_dly_timer #(.NUM_CH(1), .CNT_W(4), .PRESCALE(1)) u_dut2 (
        .clk_in(clk_in), .iRst(iRst), .dly_timer_en(en2), .dly_time(time2),
        .dly_mode(mode2), .dly_retrig(rtg2), .dly_timeout(tmo2),
        .dly_pulse(pls2), .dly_busy(busy2));

    always #5 clk_in = ~clk_in;

    int edge_n = 0;
    always @(posedge clk_in) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {int unit; int ch; int at;} exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input int u, input int c, input int at);
        exp_t e;
        e.unit = u; e.ch = c; e.at = at;
        sb.push_back(e);
    endtask

    task automatic sb_match(input int u, input int c);
        int idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].unit == u && sb[i].ch == c) idx = i;
        if (idx < 0) begin
            check_val($sformatf("pulse_u%0d_c%0d_unexpected", u, c), edge_n, -1);
        end else begin
            check_val($sformatf("pulse_u%0d_c%0d", u, c), edge_n, sb[idx].at);
            sb.delete(idx);
        end
    endtask

    // Pulse monitor: at the negedge after edge E, a high pulse means expiry at E.
    always @(negedge clk_in) begin
        if (!iRst) begin
            for (int c = 0; c < 4; c++) begin
                if (pls0[c]) sb_match(0, c);
                if (pls1[c]) sb_match(1, c);
            end
            if (pls2[0]) sb_match(2, 0);
        end
    end

    // Return at the negedge just before edge e, so inputs set now are sampled at e.
    task automatic to_edge(input int e);
        while (edge_n < e - 1) @(negedge clk_in);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int s;
        repeat (3) @(negedge clk_in);
        check_val("rst_timeout", int'(tmo0), 0);
        check_val("rst_pulse",   int'(pls0), 0);
        check_val("rst_busy",    int'(busy0), 0);
        iRst = 1'b0;
        @(negedge clk_in);

        // One-shot, N=5, start at edge 10
        t0 = edge_n + 2;
        time0[0*16 +: 16] = 16'd5;
        to_edge(t0 + 10); en0[0] = 1'b1; sb_push(0, 0, t0 + 16);
        to_edge(t0 + 11);
        check_val("os_busy_start", int'(busy0), 1);
        check_val("os_tmo_early",  int'(tmo0[0]), 0);
        to_edge(t0 + 16);
        check_val("os_busy_mid",   int'(busy0), 1);
        check_val("os_tmo_before", int'(tmo0[0]), 0);
        to_edge(t0 + 17);
        check_val("os_tmo_set",    int'(tmo0[0]), 1);
        check_val("os_busy_done",  int'(busy0), 0);
        to_edge(t0 + 19);
        check_val("os_tmo_hold",   int'(tmo0[0]), 1);
        to_edge(t0 + 20); en0[0] = 1'b0;
        to_edge(t0 + 21);
        check_val("os_tmo_abort",  int'(tmo0[0]), 0);

        // Periodic, PRESCALE=4, N=2, enable dropped at edge 30
        t0 = edge_n + 2;
        time1[1*16 +: 16] = 16'd2; mode1[1] = 1'b1;
        to_edge(t0); en1[1] = 1'b1;
        sb_push(1, 1, t0 + 12); sb_push(1, 1, t0 + 24);
        to_edge(t0 + 13);
        check_val("per_tmo_0", int'(tmo1[1]), 0);
        to_edge(t0 + 25);
        check_val("per_tmo_1", int'(tmo1[1]), 0);
        to_edge(t0 + 30); en1[1] = 1'b0;
        to_edge(t0 + 40);
        check_val("per_busy_off", int'(busy1), 0);

        // Retrigger, one-shot N=9
        t0 = edge_n + 2;
        time0[2*16 +: 16] = 16'd9;
        to_edge(t0);      en0[2] = 1'b1;
        to_edge(t0 + 5);  rtg0[2] = 1'b1;
        to_edge(t0 + 6);  rtg0[2] = 1'b0;
        to_edge(t0 + 13); rtg0[2] = 1'b1; sb_push(0, 2, t0 + 23);
        to_edge(t0 + 14); rtg0[2] = 1'b0;
        to_edge(t0 + 23);
        check_val("rtg_tmo_before", int'(tmo0[2]), 0);
        to_edge(t0 + 24);
        check_val("rtg_tmo_set",    int'(tmo0[2]), 1);
        to_edge(t0 + 30); rtg0[2] = 1'b1; sb_push(0, 2, t0 + 40);
        to_edge(t0 + 31); rtg0[2] = 1'b0;
        check_val("rtg_tmo_clear",  int'(tmo0[2]), 0);
        check_val("rtg_busy_again", int'(busy0), 1);
        to_edge(t0 + 41);
        check_val("rtg_tmo_reexp",  int'(tmo0[2]), 1);
        en0[2] = 1'b0;

        // Boundaries: N=0 on unit 0, N=15 on CNT_W=4 unit
        t0 = edge_n + 2;
        time0[3*16 +: 16] = 16'd0; time2 = 4'd15;
        to_edge(t0); en0[3] = 1'b1; en2 = 1'b1;
        sb_push(0, 3, t0 + 1); sb_push(2, 0, t0 + 16);
        to_edge(t0 + 2);
        check_val("n0_tmo", int'(tmo0[3]), 1);
        en0[3] = 1'b0;
        to_edge(t0 + 16);
        check_val("nmax_tmo_before", int'(tmo2), 0);
        to_edge(t0 + 17);
        check_val("nmax_tmo_set",    int'(tmo2), 1);
        en2 = 1'b0;

        // Retrigger on the expiry edge suppresses the pulse
        t0 = edge_n + 2;
        time0[0*16 +: 16] = 16'd3;
        to_edge(t0);     en0[0] = 1'b1;
        to_edge(t0 + 4); rtg0[0] = 1'b1; sb_push(0, 0, t0 + 8);
        to_edge(t0 + 5); rtg0[0] = 1'b0;
        check_val("coin_tmo", int'(tmo0[0]), 0);
        to_edge(t0 + 9);
        check_val("coin_tmo_late", int'(tmo0[0]), 1);
        en0[0] = 1'b0;

        // Reset mid-count, then restart only after an enable toggle
        t0 = edge_n + 2;
        time0[1*16 +: 16] = 16'd20; time0[3*16 +: 16] = 16'd3;
        to_edge(t0); en0[1] = 1'b1; en0[3] = 1'b1; sb_push(0, 3, t0 + 4);
        to_edge(t0 + 7);
        check_val("rst_pre_tmo",  int'(tmo0[3]), 1);
        check_val("rst_pre_busy", int'(busy0), 1);
        #2 iRst = 1'b1;
        #1;
        check_val("rst_async_tmo",  int'(tmo0), 0);
        check_val("rst_async_pls",  int'(pls0), 0);
        check_val("rst_async_busy", int'(busy0), 0);
        en0[3] = 1'b0;
        repeat (2) @(negedge clk_in);
        iRst = 1'b0;
        s = edge_n;
        to_edge(s + 5);
        check_val("rst_nostart_busy", int'(busy0), 0);
        check_val("rst_nostart_tmo",  int'(tmo0[1]), 0);
        en0[1] = 1'b0;
        @(negedge clk_in);
        en0[1] = 1'b1;
        s = edge_n + 1;
        sb_push(0, 1, s + 21);
        to_edge(s + 21);
        check_val("rst_restart_before", int'(tmo0[1]), 0);
        to_edge(s + 22);
        check_val("rst_restart_set",    int'(tmo0[1]), 1);
        en0[1] = 1'b0;

        // Independence: four channels started on one edge
        t0 = edge_n + 2;
        time0 = {16'd1, 16'd12, 16'd3, 16'd7};
        mode0 = 4'b1010;
        to_edge(t0); en0 = 4'b1111;
        sb_push(0, 0, t0 + 8);
        sb_push(0, 1, t0 + 4);  sb_push(0, 1, t0 + 8);
        sb_push(0, 2, t0 + 13);
        for (int k = 2; k <= 8; k += 2) sb_push(0, 3, t0 + k);
        to_edge(t0 + 10); en0[1] = 1'b0; en0[3] = 1'b0;
        to_edge(t0 + 13);
        check_val("ind_busy_before", int'(busy0), 1);
        to_edge(t0 + 14);
        check_val("ind_busy_after",  int'(busy0), 0);
        check_val("ind_tmo",         int'(tmo0), 5);
        en0 = '0;

        repeat (5) @(negedge clk_in);
        check_val("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
